image_writer: RTL and testbench
===============================

IMAGE_WRITER -- requirements
Module: image_writer

Interface
REQ-001 Parameter DATA_WIDTH, default 16, pixel word width.
REQ-002 Parameter IMAGE_WIDTH, default 8, pixels per row.
REQ-003 Parameter IMAGE_HEIGHT, default 8, rows per frame; ADDR_W = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  begin loading one frame; honoured only in IDLE.
REQ-007 abort  input  1  cancel the current load; no done pulse.
REQ-008 in_valid  input  1  in_data holds a pixel.
REQ-009 in_data  input  DATA_WIDTH  pixel, row-major order.
REQ-010 in_ready  output  1  writer accepts a pixel this cycle.
REQ-011 mem_we  output  1  image memory write strobe.
REQ-012 mem_addr  output  ADDR_W  image memory write address.
REQ-013 mem_wdata  output  DATA_WIDTH  image memory write data.
REQ-014 busy  output  1  high in LOAD.
REQ-015 row_done  output  1  one-cycle pulse on the write of the last pixel of each row.
REQ-016 done  output  1  one-cycle pulse after the full frame is written.
REQ-017 checksum  output  DATA_WIDTH  frame checksum (see Configuration).

Function
REQ-018 FSM states: IDLE, LOAD, DONE; IDLE->LOAD on start; LOAD->DONE on acceptance of pixel IMAGE_WIDTH*IMAGE_HEIGHT-1; DONE->IDLE unconditionally after one cycle.
REQ-019 in_ready = (state==LOAD) && !abort, combinational; a pixel is accepted when in_valid && in_ready.
REQ-020 Accepted pixel k is written at address k: mem_we=1, mem_addr=k, mem_wdata=in_data registered, one cycle after acceptance.
REQ-021 mem_we is low in every cycle not following an acceptance; in_valid gaps insert no writes and do not advance the address.
REQ-022 Address counter resets to 0 on every IDLE->LOAD transition and wraps to 0 after W*H-1; no address >= W*H is ever driven.
REQ-023 Column counter wraps at IMAGE_WIDTH-1; row_done asserts coincident with the mem_we of column IMAGE_WIDTH-1.
REQ-024 done asserts in DONE, coincident with the final pixel's mem_we cycle + 0 (same cycle as last write).
REQ-025 start in LOAD or DONE is ignored; start and abort together in IDLE: abort wins, stays IDLE.
REQ-026 abort in LOAD: return to IDLE next cycle, counters cleared, no done; a write already registered still completes.
REQ-027 Frame of 1x1 (W=H=1): first accepted pixel goes directly to DONE.

Reset
REQ-028 On reset low: state IDLE, counters 0, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, row_done=0, done=0, checksum=0, asynchronously.
REQ-029 Reset mid-LOAD discards the partial frame; no done pulse after release.

Configuration
REQ-030 Macro IMAGE_WRITER_CHECKSUM_EN defined: checksum = modulo-2^DATA_WIDTH sum of all pixels written in the current frame, cleared on IDLE->LOAD, stable from done until next start.
REQ-031 Macro undefined: checksum tied to 0, no accumulator logic; all other behaviour identical.

Verification
REQ-032 Defaults, start, 64 back-to-back pixels value=index -> writes addr 0..63 data 0..63, 8 row_done pulses, done one cycle, checksum 2016 (with macro).
REQ-033 in_valid toggled 1/0 each cycle -> only 64 writes, addresses contiguous, done after 128+ cycles.
REQ-034 abort after 10 pixels, then start, 64 pixels -> no done for first attempt; second frame writes from addr 0.
REQ-035 start pulsed during LOAD at pixel 20 -> ignored, address continues 21.
REQ-036 reset low at pixel 30 -> all outputs 0 immediately, state IDLE, no done after release.

Source files
------------

// File: rtl/image_writer_if.sv
// Pixel-stream and image-memory write bus for image_writer.
// master: pixel source / memory observer side.
// slave : the writer itself.
interface image_writer_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int IMAGE_WIDTH  = 8,
  parameter int IMAGE_HEIGHT = 8
);
  localparam int PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;
  // A 1x1 frame still needs a one-bit address bus.
  localparam int ADDR_W = (PIXELS > 1) ? $clog2(PIXELS) : 1;

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );
endinterface

// File: rtl/image_writer.sv
// image_writer: accepts one frame of row-major pixels on a valid/ready
// stream and writes pixel k to image memory address k, one cycle after
// acceptance. Pulses row_done on the last pixel of each row and done on
// the final write of the frame.
// Optional feature: define IMAGE_WRITER_CHECKSUM_EN to enable the
// modulo-2^DATA_WIDTH frame checksum; otherwise checksum is tied to 0.
module image_writer #(
  parameter int DATA_WIDTH   = 16,
  parameter int IMAGE_WIDTH  = 8,
  parameter int IMAGE_HEIGHT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  image_writer_if.slave         bus,
  output logic                  busy,
  output logic                  row_done,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] checksum
);

  localparam int PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int ADDR_W = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam int COL_W  = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMAGE_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  row_done_q, row_done_d;

  logic ready;
  logic accept;
  logic frame_start;

  // Handshake: ready only while loading and not being cancelled.
  assign ready       = (state_q == S_LOAD) && !abort;
  assign accept      = ready && bus.in_valid;
  // abort wins over start when both arrive in IDLE.
  assign frame_start = (state_q == S_IDLE) && start && !abort;

  assign bus.in_ready  = ready;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = waddr_q;
  assign bus.mem_wdata = wdata_q;
  assign busy          = (state_q == S_LOAD);
  // The final write lands in the DONE cycle, so done coincides with it.
  assign done          = (state_q == S_DONE);
  assign row_done      = row_done_q;

  // Next-state, counter and write-port logic.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    col_d      = col_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    row_done_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d = S_LOAD;
          addr_d  = '0;
          col_d   = '0;
        end
      end

      S_LOAD: begin
        if (abort) begin
          // Partial frame is dropped; a write registered last cycle still
          // goes out because we_q is not touched here.
          state_d = S_IDLE;
          addr_d  = '0;
          col_d   = '0;
        end else if (accept) begin
          we_d       = 1'b1;
          waddr_d    = addr_q;
          wdata_d    = bus.in_data;
          row_done_d = (col_q == LAST_COL);
          addr_d     = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
          col_d      = (col_q == LAST_COL) ? '0 : col_q + 1'b1;
          if (addr_q == LAST_ADDR) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        addr_d  = '0;
        col_d   = '0;
      end
    endcase
  end

  // State, counters and registered memory write port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      col_q      <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      row_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      col_q      <= col_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      row_done_q <= row_done_d;
    end
  end

`ifdef IMAGE_WRITER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;

  // Running sum of accepted pixels; cleared at frame start, held otherwise
  // so the value stays readable from done until the next start.
  always_comb begin
    sum_d = sum_q;
    if (frame_start) begin
      sum_d = '0;
    end else if (accept) begin
      sum_d = sum_q + bus.in_data;
    end
  end

  // Checksum accumulator register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_image_writer.sv
// Self-checking bench for image_writer: directed frames plus randomized
// traffic, compared cycle by cycle against a frame-level reference model.
module tb_image_writer;

  localparam int DW = 16;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int N  = W * H;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          busy;
  logic          row_done;
  logic          done;
  logic [DW-1:0] checksum;

  image_writer_if #(.DATA_WIDTH(DW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) bus();

  image_writer #(.DATA_WIDTH(DW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .bus      (bus.slave),
    .busy     (busy),
    .row_done (row_done),
    .done     (done),
    .checksum (checksum)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: frame phase (0 idle, 1 loading, 2 done), number of
  // pixels taken in this frame, running pixel sum, and the write expected
  // to appear after the next clock edge.
  int            m_phase;
  int            m_count;
  logic [DW-1:0] m_sum;
  logic          e_we;
  logic          e_rd;
  int            e_addr;
  logic [DW-1:0] e_data;

  int writes, rows, dones;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_count = 0;
    m_sum   = '0;
    e_we    = 1'b0;
    e_rd    = 1'b0;
    e_addr  = 0;
    e_data  = '0;
  endtask

  function automatic logic [31:0] exp_checksum();
`ifdef IMAGE_WRITER_CHECKSUM_EN
    return 32'(m_sum);
`else
    return 32'd0;
`endif
  endfunction

  task automatic clear_tally();
    writes = 0;
    rows   = 0;
    dones  = 0;
  endtask

  // One clock cycle: called at a falling edge, drives inputs, predicts the
  // effect of the next rising edge, then checks at the following falling edge.
  task automatic step(input logic s, input logic a, input logic v, input logic [DW-1:0] d);
    logic acc;
    start        = s;
    abort        = a;
    bus.in_valid = v;
    bus.in_data  = d;
    #1;
    check_eq("in_ready", 32'(bus.in_ready), 32'(m_phase == 1 && !a));
    acc  = v && (m_phase == 1) && !a;
    e_we = 1'b0;
    e_rd = 1'b0;
    case (m_phase)
      0: begin
        if (s && !a) begin
          m_phase = 1;
          m_count = 0;
          m_sum   = '0;
        end
      end
      1: begin
        if (a) begin
          m_phase = 0;
          m_count = 0;
        end else if (acc) begin
          e_we    = 1'b1;
          e_addr  = m_count;
          e_data  = d;
          e_rd    = ((m_count % W) == W - 1);
          m_sum   = m_sum + d;
          m_count = m_count + 1;
          if (m_count == N) begin
            m_phase = 2;
            m_count = 0;
          end
        end
      end
      default: m_phase = 0;
    endcase
    @(posedge clk);
    @(negedge clk);
    check_eq("mem_we", 32'(bus.mem_we), 32'(e_we));
    if (e_we) begin
      check_eq("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
      check_eq("mem_wdata", 32'(bus.mem_wdata), 32'(e_data));
    end
    check_eq("row_done", 32'(row_done), 32'(e_rd));
    check_eq("done", 32'(done), 32'(m_phase == 2));
    check_eq("busy", 32'(busy), 32'(m_phase == 1));
    check_eq("checksum", 32'(checksum), exp_checksum());
    if (bus.mem_we) writes++;
    if (row_done)   rows++;
    if (done)       dones++;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    check_eq({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
    check_eq({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    check_eq({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_row_done"}, 32'(row_done), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_checksum"}, 32'(checksum), 32'd0);
  endtask

  initial begin
    int cyc;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    model_reset();
    clear_tally();

    // Reset state
    #2;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Full frame, back to back, pixel value = index
    clear_tally();
    step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < N; i++) step(1'b0, 1'b0, 1'b1, DW'(i));
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    check_eq("f1_writes", 32'(writes), 32'(N));
    check_eq("f1_rows", 32'(rows), 32'(H));
    check_eq("f1_dones", 32'(dones), 32'd1);
`ifdef IMAGE_WRITER_CHECKSUM_EN
    check_eq("f1_csum", 32'(checksum), 32'd2016);
`endif

    // start and abort together in IDLE: stays idle
    step(1'b1, 1'b1, 1'b1, 16'h1234);
    step(1'b0, 1'b0, 1'b1, 16'h1234);
    check_eq("sa_busy", 32'(busy), 32'd0);

    // in_valid toggling 1/0
    clear_tally();
    step(1'b1, 1'b0, 1'b0, '0);
    cyc = 0;
    while (dones == 0 && cyc < 400) begin
      step(1'b0, 1'b0, (cyc % 2) == 0, DW'($urandom));
      cyc++;
    end
    check_eq("tog_timeout", 32'(cyc < 400), 32'd1);
    check_eq("tog_writes", 32'(writes), 32'(N));
    check_eq("tog_len", 32'(cyc >= 2 * N - 1), 32'd1);
    step(1'b0, 1'b0, 1'b0, '0);

    // Abort after 10 pixels, then a fresh frame
    clear_tally();
    step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, DW'($urandom));
    step(1'b0, 1'b1, 1'b1, DW'($urandom));
    step(1'b0, 1'b0, 1'b1, DW'($urandom));
    check_eq("ab_writes", 32'(writes), 32'd10);
    check_eq("ab_dones", 32'(dones), 32'd0);
    clear_tally();
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, 16'hBEEF);
    check_eq("ab_restart_addr", 32'(bus.mem_addr), 32'd0);
    for (int i = 1; i < N; i++) step(1'b0, 1'b0, 1'b1, DW'($urandom));
    step(1'b0, 1'b0, 1'b0, '0);
    check_eq("ab_f2_dones", 32'(dones), 32'd1);
    check_eq("ab_f2_writes", 32'(writes), 32'(N));

    // start pulsed mid-frame at pixel 20 is ignored
    clear_tally();
    step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, DW'($urandom));
    step(1'b1, 1'b0, 1'b1, DW'($urandom));
    check_eq("st_addr20", 32'(bus.mem_addr), 32'd20);
    step(1'b0, 1'b0, 1'b1, DW'($urandom));
    check_eq("st_addr21", 32'(bus.mem_addr), 32'd21);
    for (int i = 22; i < N; i++) step(1'b0, 1'b0, 1'b1, DW'($urandom));
    step(1'b0, 1'b0, 1'b0, '0);
    check_eq("st_dones", 32'(dones), 32'd1);

    // Reset mid-frame at pixel 30
    clear_tally();
    step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 1'b1, DW'($urandom));
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("midrst");
    model_reset();
    start        = 1'b0;
    abort        = 1'b0;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, DW'($urandom));
    check_eq("midrst_dones", 32'(dones), 32'd0);

    // Randomized traffic
    clear_tally();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 12) == 0, ($urandom % 80) == 0, ($urandom % 4) != 0, DW'($urandom));
    end
    check_eq("rnd_some_frames", 32'(dones > 0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
